// File: rtl/mux_arbiter_if.sv
// Bundle of the two valid/ready requester ports, the registered output slot and
// the arbiter status outputs. The arbiter connects to the slave modport. The
// master modport is the view seen by producers, the consumer and a testbench.
interface mux_arbiter_if #(
   parameter int WIDTH = 8
);

   // Requester 0
   logic             req0_valid;
   logic [WIDTH-1:0] req0_data;
   logic             req0_last;
   logic             req0_ready;

   // Requester 1
   logic             req1_valid;
   logic [WIDTH-1:0] req1_data;
   logic             req1_last;
   logic             req1_ready;

   // Output slot towards the single downstream consumer
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             out_ready;

   // Arbiter status
   logic             select;
   logic             busy;

   modport master (
      output req0_valid, req0_data, req0_last,
      input  req0_ready,
      output req1_valid, req1_data, req1_last,
      input  req1_ready,
      input  out_valid, out_data, out_last,
      output out_ready,
      input  select, busy
   );

   modport slave (
      input  req0_valid, req0_data, req0_last,
      output req0_ready,
      input  req1_valid, req1_data, req1_last,
      output req1_ready,
      output out_valid, out_data, out_last,
      input  out_ready,
      output select, busy
   );

endinterface : mux_arbiter_if

// File: rtl/mux_arbiter.sv
// Packet-level round-robin arbiter in front of one shared 2:1 datapath mux.
// The winning requester keeps the mux from the first beat of a packet to its
// last beat. The mux result is registered into a one-entry output slot. That
// slot drains and reloads in the same cycle, so it sustains one beat per cycle.
module mux_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   mux_arbiter_if.slave arb_if
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   // Arbitration state
   state_t state_q, state_d;
   logic   last_owner_q, last_owner_d;
   logic   select_q, select_d;

   // Output slot
   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic             out_last_q;

   // Combinational handshake terms
   logic             can_load;
   logic             ready0, ready1;
   logic             xfer;
   logic [WIDTH-1:0] xfer_data;
   logic             xfer_last;

   // The slot can take a new beat when it is empty or is being drained now.
   assign can_load = !out_valid_q || arb_if.out_ready;

   // Grant selection, ready generation, mux and next-state decode.
   always_comb begin
      // NOTE: every signal gets a default first, so no path through the case leaves a latch behind.
      state_d      = state_q;
      last_owner_d = last_owner_q;
      select_d     = select_q;
      ready0       = 1'b0;
      ready1       = 1'b0;

      unique case (state_q)
         IDLE: begin
            // On a tie the requester that did not own the last packet wins.
            // With no request the select keeps its previous value.
            if (arb_if.req0_valid && arb_if.req1_valid) begin
               select_d = ~last_owner_q;
            end else if (arb_if.req0_valid) begin
               select_d = 1'b0;
            end else if (arb_if.req1_valid) begin
               select_d = 1'b1;
            end
            // The grant takes effect in the same cycle. The losing requester sees ready low.
            if (select_d) begin
               ready1 = can_load && arb_if.req1_valid;
            end else begin
               ready0 = can_load && arb_if.req0_valid;
            end
         end
         OWN0: begin
            // Lock on requester 0 until its last beat, whatever requester 1 is doing.
            select_d = 1'b0;
            ready0   = can_load;
         end
         OWN1: begin
            select_d = 1'b1;
            ready1   = can_load;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // The shared 2:1 mux. Data and last both follow the select.
      xfer_data = select_d ? arb_if.req1_data : arb_if.req0_data;
      xfer_last = select_d ? arb_if.req1_last : arb_if.req0_last;
      xfer      = (ready0 && arb_if.req0_valid) || (ready1 && arb_if.req1_valid);

      // Packet boundaries drive the FSM. A stalled owner with valid low stays locked.
      if (xfer) begin
         if (xfer_last) begin
            state_d      = IDLE;
            last_owner_d = select_d;
         end else begin
            state_d = select_d ? OWN1 : OWN0;
         end
      end
   end

   // Arbitration state registers. A reset abandons any packet in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
         select_q     <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         select_q     <= select_d;
      end
   end

   // Output slot: load on a transfer, empty on a drain with nothing new, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the data register is reset as well, because the consumer must see out_data = 0 after reset.
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else if (xfer) begin
         out_valid_q <= 1'b1;
         out_data_q  <= xfer_data;
         out_last_q  <= xfer_last;
      end else if (arb_if.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign arb_if.req0_ready = ready0;
   assign arb_if.req1_ready = ready1;
   assign arb_if.out_valid  = out_valid_q;
   assign arb_if.out_data   = out_data_q;
   assign arb_if.out_last   = out_last_q;
   assign arb_if.select     = select_d;
   assign arb_if.busy       = (state_q != IDLE);

endmodule : mux_arbiter

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter. Inputs change 1 ns after a rising edge.
// Combinational readies are sampled 1 ns later. Registered outputs are
// sampled 1 ns after the edge that loads them.
module tb_mux_arbiter;

   localparam int WIDTH = 8;

   logic clk;
   logic rst_n;

   int vectors     = 0;
   int miscompares = 0;

   mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

   mux_arbiter #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .arb_if (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v0, input logic [WIDTH-1:0] d0, input logic l0,
                        input logic v1, input logic [WIDTH-1:0] d1, input logic l1);
      bus.req0_valid = v0;
      bus.req0_data  = d0;
      bus.req0_last  = l0;
      bus.req1_valid = v1;
      bus.req1_data  = d1;
      bus.req1_last  = l1;
   endtask

   initial begin
      rst_n         = 1'b1;
      bus.out_ready = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

      // 1: asynchronous reset in the middle of a cycle
      #3 rst_n = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_data", bus.out_data, 8'h00);
      check("rst_out_last", bus.out_last, 1'b0);
      check("rst_select", bus.select, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_ready0", bus.req0_ready, 1'b0);
      check("rst_ready1", bus.req1_ready, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();

      // 2: single beat from req0 with a zero-cycle grant
      bus.out_ready = 1'b1;
      drive(1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
      #1;
      check("single_ready0", bus.req0_ready, 1'b1);
      check("single_ready1", bus.req1_ready, 1'b0);
      check("single_select", bus.select, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      check("single_out_valid", bus.out_valid, 1'b1);
      check("single_out_data", bus.out_data, 8'hA5);
      check("single_out_last", bus.out_last, 1'b1);
      check("single_busy", bus.busy, 1'b0);
      tick();
      check("single_drained", bus.out_valid, 1'b0);

      // Reset pulse with no clock edge inside it, so last_owner returns to 1.
      rst_n = 1'b0;
      #2 rst_n = 1'b1;

      // 3: tie after reset. req0 goes first, then grants alternate per packet.
      drive(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1);
      #1;
      check("tie_select0", bus.select, 1'b0);
      check("tie_ready0", bus.req0_ready, 1'b1);
      check("tie_ready1", bus.req1_ready, 1'b0);
      tick();
      check("tie_out1", bus.out_data, 8'h11);
      check("tie_select1", bus.select, 1'b1);
      tick();
      check("tie_out2", bus.out_data, 8'h22);
      tick();
      check("tie_out3", bus.out_data, 8'h11);
      tick();
      check("tie_out4", bus.out_data, 8'h22);

      // 4: a 3-beat packet from req1 locks out req0 until its last beat
      drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0);
      #1;
      check("burst_b1_select", bus.select, 1'b1);
      check("burst_b1_ready1", bus.req1_ready, 1'b1);
      check("burst_b1_busy", bus.busy, 1'b0);
      tick();
      drive(1'b1, 8'h0F, 1'b1, 1'b1, 8'h02, 1'b0);
      #1;
      check("burst_out01", bus.out_data, 8'h01);
      check("burst_b2_busy", bus.busy, 1'b1);
      check("burst_b2_select", bus.select, 1'b1);
      check("burst_b2_ready0", bus.req0_ready, 1'b0);
      check("burst_b2_ready1", bus.req1_ready, 1'b1);
      tick();
      drive(1'b1, 8'h0F, 1'b1, 1'b1, 8'h03, 1'b1);
      #1;
      check("burst_out02", bus.out_data, 8'h02);
      check("burst_b3_busy", bus.busy, 1'b1);
      check("burst_b3_ready0", bus.req0_ready, 1'b0);
      check("burst_b3_select", bus.select, 1'b1);
      tick();
      drive(1'b1, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b0);
      #1;
      check("burst_out03", bus.out_data, 8'h03);
      check("burst_out03_last", bus.out_last, 1'b1);
      check("burst_end_busy", bus.busy, 1'b0);
      check("burst_end_select", bus.select, 1'b0);
      check("burst_end_ready0", bus.req0_ready, 1'b1);
      tick();
      check("burst_out0F", bus.out_data, 8'h0F);
      check("burst_out0F_last", bus.out_last, 1'b1);

      // 5: backpressure holds the slot, then it drains and reloads in one cycle
      bus.out_ready = 1'b0;
      drive(1'b1, 8'h44, 1'b1, 1'b1, 8'h55, 1'b1);
      #1;
      check("bp_ready0", bus.req0_ready, 1'b0);
      check("bp_ready1", bus.req1_ready, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_valid", bus.out_valid, 1'b1);
         check("bp_hold_data", bus.out_data, 8'h0F);
         check("bp_hold_ready0", bus.req0_ready, 1'b0);
         check("bp_hold_ready1", bus.req1_ready, 1'b0);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_ready1", bus.req1_ready, 1'b1);
      check("bp_release_ready0", bus.req0_ready, 1'b0);
      check("bp_release_select", bus.select, 1'b1);
      tick();
      check("bp_reload_valid", bus.out_valid, 1'b1);
      check("bp_reload_data", bus.out_data, 8'h55);
      check("bp_next_select", bus.select, 1'b0);
      check("bp_next_ready0", bus.req0_ready, 1'b1);
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      check("bp_reload2_data", bus.out_data, 8'h44);
      tick();
      check("bp_empty", bus.out_valid, 1'b0);

      // 6: reset after beat 1 of a 3-beat req0 packet
      drive(1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      drive(1'b1, 8'hA2, 1'b0, 1'b0, 8'h00, 1'b0);
      check("mid_busy", bus.busy, 1'b1);
      check("mid_out_data", bus.out_data, 8'hA1);
      #1 rst_n = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      #1;
      check("mid_rst_busy", bus.busy, 1'b0);
      check("mid_rst_out_valid", bus.out_valid, 1'b0);
      check("mid_rst_select", bus.select, 1'b0);
      check("mid_rst_ready0", bus.req0_ready, 1'b0);
      tick();
      check("mid_rst_hold_valid", bus.out_valid, 1'b0);
      #2 rst_n = 1'b1;
      drive(1'b1, 8'hB0, 1'b1, 1'b1, 8'hB1, 1'b1);
      #1;
      check("post_rst_select", bus.select, 1'b0);
      check("post_rst_ready0", bus.req0_ready, 1'b1);
      check("post_rst_ready1", bus.req1_ready, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      check("post_rst_out_data", bus.out_data, 8'hB0);
      check("post_rst_out_valid", bus.out_valid, 1'b1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_mux_arbiter
